mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage LoongArch-subset pipeline. It takes instructions from the execute stage over the EX→MS bus, collects the synchronous data-SRAM read data that belongs to loads issued in EX, and aligns and extends that data for byte, halfword and word loads. It forwards the final result to writeback and publishes a bypass/hazard bus back to decode. It closes the data-SRAM access loop that EX opens.

## Interface

Parameters: none. Bus widths come from `mycpu.vh`:
- `ES_TO_MS_BUS_WD` = 75
- `MS_TO_WS_BUS_WD` = 70
- `MS_FWD_BUS_WD` = 39

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- resetn  in  1  Synchronous, active-low reset.
- ws_allowin  in  1  Writeback can accept an instruction this cycle.
- ms_allowin  out  1  MS can accept an instruction from EX this cycle.
- es_to_ms_valid  in  1  EX presents a valid instruction.
- es_to_ms_bus  in  75  Fields, MSB first:
  - mem_size[1:0] at [74:73]: 0 = byte, 1 = half, 2 = word.
  - mem_unsigned at [72].
  - store_op at [71].
  - load_op at [70].
  - gr_we at [69].
  - dest[4:0] at [68:64].
  - alu_result[31:0] at [63:32].
  - pc[31:0] at [31:0].
- data_sram_rdata  in  32  Read data for the request EX issued in the previous cycle.
- ms_to_ws_valid  out  1  MS presents a valid instruction to WB.
- ms_to_ws_bus  out  70  Fields, MSB first:
  - gr_we at [69].
  - dest[4:0] at [68:64].
  - final_result[31:0] at [63:32].
  - pc[31:0] at [31:0].
- ms_fwd_bus  out  39  Fields, MSB first:
  - fwd_we at [38]: ms_valid & gr_we & (dest≠0).
  - fwd_is_load at [37].
  - fwd_ready at [36]: final_result is valid this cycle.
  - fwd_dest[4:0] at [35:31]. (Bit 31 is shared; see below.)
  - fwd_result[31:0]: lower bits.
  - Layout decision: the bus is 39 bits = {fwd_we, fwd_is_load, fwd_ready, fwd_dest[4:0], fwd_result[31:1]}. Bit 0 of fwd_result is carried by dropping it. That layout is rejected. The bus is 40 bits: {fwd_we, fwd_is_load, fwd_ready, dest[4:0], fwd_result[31:0]}, and `MS_FWD_BUS_WD` = 40.

## Operation

- Pipeline register:
  - On a clock edge with ms_allowin=1, ms_valid ← es_to_ms_valid.
  - On that same edge, bus_r ← es_to_ms_bus when es_to_ms_valid=1.
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Read-data capture:
  - data_sram_rdata belongs to the MS instruction only in its first cycle in MS, i.e. the cycle after the EX→MS transfer edge.
  - first_cycle flag:
    - Set on every transfer edge that loads a valid instruction.
    - Cleared on the next edge.
  - On the first_cycle edge, rdata_buf ← data_sram_rdata.
  - rdata_sel = first_cycle ? data_sram_rdata : rdata_buf.
  - Result: a WB stall of any length never loses load data.
- Load alignment, with a = alu_result[1:0]:
  - Byte: rdata_sel[8a+7:8a], zero-extended if mem_unsigned, otherwise sign-extended.
  - Half: rdata_sel[16·a[1]+15:16·a[1]], zero- or sign-extended the same way. a[0] is ignored; misalignment is handled by the exception logic elsewhere.
  - Word: rdata_sel.
  - mem_size=3: treated as word.
- final_result:
  - load_op=1: the aligned load data.
  - Otherwise: alu_result.
  - Stores pass alu_result. gr_we is taken as given on the bus.
- Forwarding:
  - fwd_ready = 1 for non-loads.
  - fwd_ready = 1 for loads; data is always available in MS.
  - fwd_is_load lets decode apply a load-use policy if it chooses.
  - fwd_we = 0 whenever ms_valid = 0.

## Timing

- Reset, while resetn=0 at an edge:
  - ms_valid, first_cycle and bus_r are cleared to 0.
  - rdata_buf is cleared to 0.
  - Outputs after reset: ms_allowin=1, ms_to_ws_valid=0, ms_to_ws_bus=0, fwd_we=0.
- Latency: one cycle from the EX→MS transfer edge to the appearance on ms_to_ws_bus. The path from data_sram_rdata to final_result is combinational.
- Stall: with ms_valid=1 and ws_allowin=0:
  - bus_r, rdata_buf and the outputs hold.
  - first_cycle falls after one cycle.
  - ms_allowin=0.
- Simultaneous transfers: a transfer MS→WB and a transfer EX→MS on the same edge replace the instruction. first_cycle is re-set.
- A bubble (es_to_ms_valid=0) accepted while ms_allowin=1 clears ms_valid. bus_r holds.
- resetn deasserted mid-stall: the instruction is discarded on the reset edge, with no output glitch after it.

## Test plan

- Reset: hold resetn=0 for 3 cycles -> ms_allowin=1, ms_to_ws_valid=0, ms_to_ws_bus=0, fwd_we=0.
- Word load:
  - Stimulus: alu_result=0x1000_0008, and rdata=0xDEAD_BEEF in the cycle after transfer.
  - Response: final_result=0xDEAD_BEEF, fwd_we=1, fwd_is_load=1.
- Byte loads with rdata=0x80F1_7F22:
  - ld.b at a=3: result 0xFFFF_FF80.
  - ld.bu at a=3: result 0x0000_0080.
  - ld.b at a=1: result 0x0000_007F.
- Half loads with rdata=0x8001_F0F0:
  - ld.h at a=2: result 0xFFFF_8001.
  - ld.hu at a=0: result 0x0000_F0F0.
- Stall:
  - Stimulus: a load with rdata=0x1234_5678 in its first cycle, then rdata=0xFFFF_FFFF while ws_allowin=0 for 4 cycles.
  - Response: final_result stays 0x1234_5678 and ms_allowin=0 throughout.
- Back-to-back ALU ops with ws_allowin=1 every cycle:
  - Stimulus: pc values 0x1c00_0000 and 0x1c00_0004.
  - Response: each appears for exactly one cycle. A dest=0 op gives fwd_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: captures data-SRAM read data for loads issued in EX,
// aligns/extends it, and forwards the result to writeback and decode.
package mem_stage_pkg;
    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 40;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_e;

    typedef struct packed {
        mem_size_e   mem_size;
        logic        mem_unsigned;
        logic        store_op;
        logic        load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    logic        r_ms_valid;
    logic        r_first_cycle;
    es_to_ms_t   r_bus;
    logic [31:0] r_rdata_buf;

    logic        w_ms_ready_go;
    logic        w_transfer_in;
    logic [31:0] w_rdata_sel;
    logic [1:0]  w_addr_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic        w_fwd_we;

    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_transfer_in  = ms_allowin && es_to_ms_valid;

    // NOTE: every register here uses <= so all of them sample pre-edge values;
    // blocking assignments would let later statements see the updated state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ms_valid    <= 1'b0;
            r_first_cycle <= 1'b0;
            r_bus         <= '0;
            r_rdata_buf   <= '0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_transfer_in) begin
                r_bus <= es_to_ms_bus;
            end
            // SRAM data is only valid in the instruction's first MS cycle;
            // the buffer keeps it alive across any writeback stall.
            r_first_cycle <= w_transfer_in;
            if (r_first_cycle) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign w_rdata_sel = r_first_cycle ? data_sram_rdata : r_rdata_buf;
    assign w_addr_lo   = r_bus.alu_result[1:0];

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_byte      = w_rdata_sel[7:0];
        w_half      = w_rdata_sel[15:0];
        w_load_data = w_rdata_sel;
        case (w_addr_lo)
            2'd0:    w_byte = w_rdata_sel[7:0];
            2'd1:    w_byte = w_rdata_sel[15:8];
            2'd2:    w_byte = w_rdata_sel[23:16];
            default: w_byte = w_rdata_sel[31:24];
        endcase
        if (w_addr_lo[1]) begin
            w_half = w_rdata_sel[31:16];
        end
        case (r_bus.mem_size)
            SIZE_BYTE: w_load_data = r_bus.mem_unsigned ? {24'd0, w_byte}
                                                        : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: w_load_data = r_bus.mem_unsigned ? {16'd0, w_half}
                                                        : {{16{w_half[15]}}, w_half};
            default:   w_load_data = w_rdata_sel;
        endcase
    end

    assign w_final_result = r_bus.load_op ? w_load_data : r_bus.alu_result;
    assign w_fwd_we       = r_ms_valid && r_bus.gr_we && (r_bus.dest != 5'd0);

    assign ms_to_ws_bus = {r_bus.gr_we, r_bus.dest, w_final_result, r_bus.pc};
    assign ms_fwd_bus   = {w_fwd_we, r_bus.load_op, 1'b1, r_bus.dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected WB/forward
// values, a negedge monitor pops and compares on every MS->WB handoff.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [69:0] bus;
        logic        fwd_we;
        logic        is_load;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [31:0]                data_sram_rdata;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    mem_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_allowin     (ws_allowin),
        .ms_allowin     (ms_allowin),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ms_fwd_bus     (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic es_to_ms_t mk(input logic [1:0] size, input logic uns, input logic st,
                                     input logic ld, input logic we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
        es_to_ms_t b;
        b.mem_size     = mem_size_e'(size);
        b.mem_unsigned = uns;
        b.store_op     = st;
        b.load_op      = ld;
        b.gr_we        = we;
        b.dest         = dest;
        b.alu_result   = alu;
        b.pc           = pc;
        return b;
    endfunction

    task automatic expect_out(input logic we, input logic [4:0] dest, input logic [31:0] res,
                              input logic [31:0] pc, input logic fwd_we, input logic is_load);
        exp_t e;
        e.bus     = {we, dest, res, pc};
        e.fwd_we  = fwd_we;
        e.is_load = is_load;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input es_to_ms_t b, input logic [31:0] rd);
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        data_sram_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handoff to WB happens on the next edge whenever valid && ws_allowin.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 70'(ms_to_ws_valid), 70'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ws_bus", ms_to_ws_bus, e.bus);
                check("fwd_we", 70'(ms_fwd_bus[39]), 70'(e.fwd_we));
                check("fwd_is_load", 70'(ms_fwd_bus[38]), 70'(e.is_load));
                check("fwd_ready", 70'(ms_fwd_bus[37]), 70'd1);
                check("fwd_dest", 70'(ms_fwd_bus[36:32]), 70'(e.bus[68:64]));
                check("fwd_result", 70'(ms_fwd_bus[31:0]), 70'(e.bus[63:32]));
            end
        end
    end

    localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

    initial begin
        es_to_ms_t nop;
        nop             = '0;
        resetn          = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = JUNK;
        repeat (3) @(posedge clk);
        #1;
        check("rst_allowin", 70'(ms_allowin), 70'd1);
        check("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        check("rst_bus", ms_to_ws_bus, 70'd0);
        check("rst_fwd_we", 70'(ms_fwd_bus[39]), 70'd0);
        resetn = 1'b1;

        // Word load, then a bubble: valid drops, bus_r holds.
        drive(1'b1, mk(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h1000_0008, 32'h1c00_0100), JUNK);
        expect_out(1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1c00_0100, 1'b1, 1'b1);
        drive(1'b0, nop, 32'hDEAD_BEEF);
        check("bubble_valid", 70'(ms_to_ws_valid), 70'd0);
        check("bubble_fwd_we", 70'(ms_fwd_bus[39]), 70'd0);
        check("bubble_bus_hold", 70'(ms_to_ws_bus[31:0]), 70'(32'h1c00_0100));

        // Back-to-back byte loads, rdata for each in its own first cycle.
        drive(1'b1, mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1000_0003, 32'h1c00_0200), JUNK);
        expect_out(1'b1, 5'd5, 32'hFFFF_FF80, 32'h1c00_0200, 1'b1, 1'b1);
        drive(1'b1, mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h1000_0003, 32'h1c00_0204), 32'h80F1_7F22);
        expect_out(1'b1, 5'd6, 32'h0000_0080, 32'h1c00_0204, 1'b1, 1'b1);
        drive(1'b1, mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1000_0001, 32'h1c00_0208), 32'h80F1_7F22);
        expect_out(1'b1, 5'd7, 32'h0000_007F, 32'h1c00_0208, 1'b1, 1'b1);
        // Half loads; a[0] is ignored, mem_size=3 acts as word.
        drive(1'b1, mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'h1000_0002, 32'h1c00_0300), 32'h80F1_7F22);
        expect_out(1'b1, 5'd8, 32'hFFFF_8001, 32'h1c00_0300, 1'b1, 1'b1);
        drive(1'b1, mk(2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h1000_0000, 32'h1c00_0304), 32'h8001_F0F0);
        expect_out(1'b1, 5'd9, 32'h0000_F0F0, 32'h1c00_0304, 1'b1, 1'b1);
        drive(1'b1, mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'h1000_0003, 32'h1c00_0308), 32'h8001_F0F0);
        expect_out(1'b1, 5'd10, 32'hFFFF_8001, 32'h1c00_0308, 1'b1, 1'b1);
        drive(1'b1, mk(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h1000_0001, 32'h1c00_030c), 32'h8001_F0F0);
        expect_out(1'b1, 5'd11, 32'hC0DE_0001, 32'h1c00_030c, 1'b1, 1'b1);
        drive(1'b0, nop, 32'hC0DE_0001);

        // Stall: load data must survive 4 extra cycles of ws_allowin=0.
        drive(1'b1, mk(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h1000_0010, 32'h1c00_0400), JUNK);
        expect_out(1'b1, 5'd12, 32'h1234_5678, 32'h1c00_0400, 1'b1, 1'b1);
        ws_allowin      = 1'b0;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234_5678));
            check("stall_allowin", 70'(ms_allowin), 70'd0);
            @(posedge clk);
            #1;
            data_sram_rdata = 32'hFFFF_FFFF;
        end
        ws_allowin = 1'b1;
        drive(1'b0, nop, 32'hFFFF_FFFF);

        // Back-to-back ALU ops, a dest=0 op, and a store.
        drive(1'b1, mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0011, 32'h1c00_0000), JUNK);
        expect_out(1'b1, 5'd3, 32'h0000_0011, 32'h1c00_0000, 1'b1, 1'b0);
        drive(1'b1, mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0022, 32'h1c00_0004), JUNK);
        expect_out(1'b1, 5'd0, 32'h0000_0022, 32'h1c00_0004, 1'b0, 1'b0);
        drive(1'b1, mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1000_0040, 32'h1c00_0008), JUNK);
        expect_out(1'b0, 5'd0, 32'h1000_0040, 32'h1c00_0008, 1'b0, 1'b0);
        drive(1'b0, nop, JUNK);
        drive(1'b0, nop, JUNK);

        // Reset mid-stall discards the instruction without an output glitch.
        drive(1'b1, mk(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 32'h1000_0020, 32'h1c00_0500), JUNK);
        ws_allowin = 1'b0;
        drive(1'b0, nop, 32'h0BAD_0BAD);
        check("stall_pre_reset_valid", 70'(ms_to_ws_valid), 70'd1);
        resetn = 1'b0;
        drive(1'b0, nop, JUNK);
        check("midrst_valid", 70'(ms_to_ws_valid), 70'd0);
        check("midrst_bus", ms_to_ws_bus, 70'd0);
        resetn     = 1'b1;
        ws_allowin = 1'b1;
        drive(1'b0, nop, JUNK);
        check("post_rst_valid", 70'(ms_to_ws_valid), 70'd0);
        check("post_rst_allowin", 70'(ms_allowin), 70'd1);

        repeat (3) @(posedge clk);
        check("sb_drained", 70'(sb.size()), 70'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
